// File: rtl/arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arbiter_pkg                                               |
// | Purpose  : Shared state encoding and pointer helper for the arbiter  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Explicit wrap so a non-power-of-2 requester count never yields an index >= width.
   function automatic logic [31:0] rr_next_ptr(input logic [31:0] idx, input logic [31:0] width);
      return (idx == width - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_base.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : priority_encoder_base                                     |
// | Purpose  : Lowest-set-bit priority encoder, index plus valid flag     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module priority_encoder_base #(
   parameter  int WIDTH          = 32,
   parameter  int IMPLEMENTATION = 0,
   localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     enc_in,
   output logic [WIDTH_LOG-1:0] enc_idx,
   output logic                 enc_vld
);

   assign enc_vld = |enc_in;

   generate
      if (IMPLEMENTATION == 1) begin : g_lsb
         // Isolate the lowest set bit, then OR together the indices of the single hot bit.
         logic [WIDTH-1:0] w_lsb;
         assign w_lsb = enc_in & (~enc_in + WIDTH'(1));
         always_comb begin
            enc_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (w_lsb[i]) enc_idx = enc_idx | i[WIDTH_LOG-1:0];
            end
         end
      end else begin : g_loop
         always_comb begin
            enc_idx = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (enc_in[i]) enc_idx = i[WIDTH_LOG-1:0];
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/arbiter_round_robin.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arbiter_round_robin                                       |
// | Purpose  : Registered round-robin arbiter with valid/ready grant     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module arbiter_round_robin
   import arbiter_pkg::*;
#(
   parameter  int WIDTH     = 32,
   parameter  int ENC_IMPL  = 0,
   localparam int WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     req,
   output logic                 gnt_vld,
   input  logic                 gnt_rdy,
   output logic [WIDTH_LOG-1:0] gnt_idx,
   output logic [WIDTH-1:0]     gnt_oh
);

   arb_state_t           r_state;
   logic [WIDTH_LOG-1:0] r_ptr;
   logic                 r_gnt_vld;
   logic [WIDTH_LOG-1:0] r_gnt_idx;
   logic [WIDTH-1:0]     r_gnt_oh;

   logic                 w_xfer;
   logic [WIDTH_LOG-1:0] w_ptr_nxt;
   logic [WIDTH_LOG-1:0] w_ptr_eff;
   logic [WIDTH-1:0]     w_mreq;
   logic [WIDTH_LOG-1:0] w_midx;
   logic [WIDTH_LOG-1:0] w_uidx;
   logic                 w_mvld;
   logic                 w_uvld;
   logic [WIDTH_LOG-1:0] w_win;

   assign w_xfer    = r_gnt_vld & gnt_rdy;
   assign w_ptr_nxt = WIDTH_LOG'(rr_next_ptr(32'(r_gnt_idx), 32'(WIDTH)));
   // In a transfer cycle the search already starts just above the departing winner.
   assign w_ptr_eff = w_xfer ? w_ptr_nxt : r_ptr;
   assign w_mreq    = req & ~((WIDTH'(1) << w_ptr_eff) - WIDTH'(1));

   priority_encoder_base #(.WIDTH(WIDTH), .IMPLEMENTATION(ENC_IMPL)) u_enc_masked (
      .enc_in  (w_mreq),
      .enc_idx (w_midx),
      .enc_vld (w_mvld)
   );

   priority_encoder_base #(.WIDTH(WIDTH), .IMPLEMENTATION(ENC_IMPL)) u_enc_unmasked (
      .enc_in  (req),
      .enc_idx (w_uidx),
      .enc_vld (w_uvld)
   );

   assign w_win = w_mvld ? w_midx : w_uidx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_gnt_vld <= 1'b0;
         r_gnt_idx <= '0;
         r_gnt_oh  <= '0;
      end else begin
         if (w_xfer) r_ptr <= w_ptr_nxt;
         case (r_state)
            IDLE: begin
               if (w_uvld) begin
                  r_state   <= GRANT;
                  r_gnt_vld <= 1'b1;
                  r_gnt_idx <= w_win;
                  r_gnt_oh  <= WIDTH'(1) << w_win;
               end
            end
            GRANT: begin
               if (gnt_rdy) begin
                  if (w_uvld) begin
                     r_gnt_idx <= w_win;
                     r_gnt_oh  <= WIDTH'(1) << w_win;
                  end else begin
                     r_state   <= IDLE;
                     r_gnt_vld <= 1'b0;
                     r_gnt_oh  <= '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt_vld = r_gnt_vld;
   assign gnt_idx = r_gnt_idx;
   assign gnt_oh  = r_gnt_oh;

`ifndef SYNTHESIS
   a_onehot: assert property (@(posedge clk) (!rst && r_gnt_vld) |-> $onehot(r_gnt_oh));
   a_hold:   assert property (@(posedge clk) (!rst && r_gnt_vld && !gnt_rdy) |=> (r_gnt_idx == $past(r_gnt_idx)));
   a_range:  assert property (@(posedge clk) (32'(r_gnt_idx) < 32'(WIDTH)));
   a_no_x:   assert property (@(posedge clk) !rst |-> !$isunknown({req, gnt_rdy}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_arbiter_round_robin.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_arbiter_round_robin                                    |
// | Purpose  : Directed vector table plus model-checked random traffic   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_arbiter_round_robin;

   logic       clk = 1'b0;
   logic       rst4 = 1'b1;
   logic [3:0] req4 = '0;
   logic       rdy4 = 1'b0;
   logic       gnt_vld4;
   logic [1:0] gnt_idx4;
   logic [3:0] gnt_oh4;

   logic       rst5 = 1'b1;
   logic [4:0] req5 = '0;
   logic       rdy5 = 1'b0;
   logic       gnt_vld5;
   logic [2:0] gnt_idx5;
   logic [4:0] gnt_oh5;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   arbiter_round_robin #(.WIDTH(4), .ENC_IMPL(0)) dut4 (
      .clk(clk), .rst(rst4), .req(req4), .gnt_vld(gnt_vld4),
      .gnt_rdy(rdy4), .gnt_idx(gnt_idx4), .gnt_oh(gnt_oh4)
   );

   arbiter_round_robin #(.WIDTH(5), .ENC_IMPL(0)) dut5 (
      .clk(clk), .rst(rst5), .req(req5), .gnt_vld(gnt_vld5),
      .gnt_rdy(rdy5), .gnt_idx(gnt_idx5), .gnt_oh(gnt_oh5)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic       vld;
      logic [1:0] idx;
      logic [3:0] oh;
      logic       chk_idx;
   } vec_t;

   vec_t tbl[29];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (p + k) % 4;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   initial begin
      // fields: rst, req, rdy | expected vld, idx, oh, idx-checked
      tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[5]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
      tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
      tbl[7]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
      tbl[8]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[9]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
      tbl[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[11] = '{1'b0, 4'h5, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[12] = '{1'b0, 4'h5, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[13] = '{1'b0, 4'h5, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[14] = '{1'b0, 4'h5, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[15] = '{1'b0, 4'h5, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
      tbl[16] = '{1'b0, 4'h5, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[17] = '{1'b0, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
      tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1};
      tbl[19] = '{1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1};
      tbl[20] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
      tbl[21] = '{1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
      tbl[22] = '{1'b0, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1};
      tbl[23] = '{1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
      tbl[24] = '{1'b1, 4'h8, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
      tbl[25] = '{1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1};
      tbl[26] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
      tbl[27] = '{1'b0, 4'h3, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
      tbl[28] = '{1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};

      for (int v = 0; v < 29; v++) begin
         rst4 = tbl[v].rst;
         req4 = tbl[v].req;
         rdy4 = tbl[v].rdy;
         tick();
         chk($sformatf("vec%0d_vld", v), 32'(gnt_vld4), 32'(tbl[v].vld));
         chk($sformatf("vec%0d_oh", v), 32'(gnt_oh4), 32'(tbl[v].oh));
         if (tbl[v].chk_idx) chk($sformatf("vec%0d_idx", v), 32'(gnt_idx4), 32'(tbl[v].idx));
      end

      // Five requesters: wrap from index 4 back to 0 without an out-of-range index.
      rst5 = 1'b1; tick();
      rst5 = 1'b0; req5 = 5'b10000; rdy5 = 1'b0; tick();
      chk("w5_first_idx", 32'(gnt_idx5), 32'd4);
      chk("w5_first_oh", 32'(gnt_oh5), 32'h10);
      req5 = 5'b10001; rdy5 = 1'b1; tick();
      chk("w5_wrap_idx", 32'(gnt_idx5), 32'd0);
      chk("w5_wrap_oh", 32'(gnt_oh5), 32'h01);
      tick();
      chk("w5_next_idx", 32'(gnt_idx5), 32'd4);
      tick();
      chk("w5_wrap2_idx", 32'(gnt_idx5), 32'd0);
      chk("w5_vld", 32'(gnt_vld5), 32'd1);
      chk("w5_range", 32'(gnt_idx5 < 3'd5), 32'd1);
      req5 = '0; rdy5 = 1'b0; rst5 = 1'b1;

      // Random traffic against a reference model with a fairness bound.
      begin
         bit m_vld;
         int m_idx, m_ptr, p, w, max_wait;
         bit xfer;
         int wait_cnt[4];
         m_vld = 0; m_idx = 0; m_ptr = 0; max_wait = 0;
         for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
         rst4 = 1'b1; req4 = '0; rdy4 = 1'b0; tick();
         rst4 = 1'b0;
         for (int c = 0; c < 2000; c++) begin
            req4 = 4'($urandom);
            rdy4 = ($urandom_range(0, 3) != 0);
            xfer = m_vld && rdy4;
            p = xfer ? ((m_idx == 3) ? 0 : m_idx + 1) : m_ptr;
            w = rr_pick(req4, p);
            for (int i = 0; i < 4; i++) begin
               if (!req4[i]) wait_cnt[i] = 0;
               else if (xfer && m_idx == i) wait_cnt[i] = 0;
               else if (xfer) wait_cnt[i]++;
               if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            if (xfer) m_ptr = p;
            if (!m_vld) begin
               if (req4 != 0) begin m_vld = 1; m_idx = w; end
            end else if (xfer) begin
               if (req4 != 0) m_idx = w;
               else m_vld = 0;
            end
            tick();
            chk("rnd_vld", 32'(gnt_vld4), 32'(m_vld));
            chk("rnd_oh", 32'(gnt_oh4), m_vld ? (32'd1 << m_idx) : 32'd0);
            if (m_vld) chk("rnd_idx", 32'(gnt_idx4), 32'(m_idx));
         end
         chk("starvation_bound", 32'(max_wait <= 4), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
